// File: rtl/spi_controller_if.sv
// Request handshake, status and SPI bus signals of spi_controller.
// master: the controller side (drives the SPI bus and status).
// slave:  the requester/peripheral side.
interface spi_controller_if;
   logic       req_valid;
   logic       req_ready;
   logic [6:0] req_addr;
   logic [7:0] req_data;
   logic       busy;
   logic       done;
   logic       err;
   logic       SCLK;
   logic       COPI;
   logic       nCS;

   modport master (
      input  req_valid, req_addr, req_data,
      output req_ready, busy, done, err, SCLK, COPI, nCS
   );

   modport slave (
      output req_valid, req_addr, req_data,
      input  req_ready, busy, done, err, SCLK, COPI, nCS
   );
endinterface

// File: rtl/spi_controller.sv
// Write-only SPI controller, mode 0, MSB first.
// Frame: {1'b1 (write), addr[6:0], data[7:0]}, SCLK half-period = CLK_DIV clk cycles.
// Optional macro SPI_CTRL_ADDR_CHECK_EN: requests with req_addr > 7'h04 are rejected
// with a one-cycle err pulse and produce no bus activity.
module spi_controller #(
   parameter int CLK_DIV = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   spi_controller_if.master bus
);
   localparam int PW = $clog2(CLK_DIV) + 1;
   localparam logic [PW-1:0] PH_LAST  = PW'(CLK_DIV - 1);
   localparam logic [PW-1:0] GAP_LAST = PW'(CLK_DIV - 2);

   typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;

   state_t        state, state_d;
   logic [PW-1:0] phase;
   logic [4:0]    bit_cnt;
   logic [15:0]   shreg;
   logic          ready_q, busy_q, done_q, sclk_q, copi_q, ncs_q;
   logic          ready_d, done_d, sclk_d, copi_d, ncs_d;
   logic          accept, addr_bad, phase_end, shift_edge;

   assign accept     = bus.req_valid && ready_q;
   assign phase_end  = (phase == PH_LAST);
   assign shift_edge = (state == S_HIGH) && (state_d == S_LOW);

`ifdef SPI_CTRL_ADDR_CHECK_EN
   logic err_q;
   assign addr_bad = (bus.req_addr > 7'h04);
   // Reject pulse for an out-of-range address, one cycle after the accept edge
   always_ff @(posedge clk) begin
      if (!rst_n) err_q <= 1'b0;
      else        err_q <= accept && addr_bad;
   end
   assign bus.err = err_q;
`else
   assign addr_bad = 1'b0;
   assign bus.err  = 1'b0;
`endif

   // Next-state and next registered-output values
   always_comb begin
      state_d = state;
      case (state)
         S_IDLE:  if (accept && !addr_bad) state_d = S_SETUP;
         S_SETUP: if (phase_end) state_d = S_HIGH;
         S_HIGH:  if (phase_end) state_d = S_LOW;
         S_LOW:   if (phase_end) state_d = (bit_cnt == 5'd16) ? S_GAP : S_HIGH;
         // GAP ends one cycle early: the following IDLE cycle completes the
         // CLK_DIV-cycle nCS-high gap, so accepts can be 34*CLK_DIV apart.
         S_GAP:   if (phase == GAP_LAST) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      ncs_d   = !(state_d == S_SETUP || state_d == S_HIGH || state_d == S_LOW);
      sclk_d  = (state_d == S_HIGH);
      ready_d = (state_d == S_IDLE);
      done_d  = (state == S_LOW) && (state_d == S_GAP);
      copi_d  = copi_q;
      if (ncs_d)
         copi_d = 1'b0;
      else if (state == S_IDLE)
         copi_d = 1'b1;                 // frame[15], the write flag
      else if (shift_edge && bit_cnt != 5'd15)
         copi_d = shreg[14];            // next bit; after bit 0 COPI holds
   end

   // State register and phase counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= S_IDLE;
         phase <= '0;
      end else begin
         state <= state_d;
         phase <= (state_d != state || state == S_IDLE) ? '0 : phase + 1'b1;
      end
   end

   // Frame shift register and bit counter
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bit_cnt <= '0;
         shreg   <= '0;
      end else if (accept) begin
         bit_cnt <= '0;
         shreg   <= {1'b1, bus.req_addr, bus.req_data};
      end else if (shift_edge) begin
         bit_cnt <= bit_cnt + 1'b1;
         if (bit_cnt != 5'd15) shreg <= {shreg[14:0], 1'b0};
      end
   end

   // Registered bus and status outputs
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sclk_q  <= 1'b0;
         copi_q  <= 1'b0;
         ncs_q   <= 1'b1;
      end else begin
         ready_q <= ready_d;
         busy_q  <= !ready_d;
         done_q  <= done_d;
         sclk_q  <= sclk_d;
         copi_q  <= copi_d;
         ncs_q   <= ncs_d;
      end
   end

   assign bus.req_ready = ready_q;
   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.SCLK      = sclk_q;
   assign bus.COPI      = copi_q;
   assign bus.nCS       = ncs_q;
endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: CLK_DIV=4 instance (a) and CLK_DIV=2 instance (b),
// each observed by a small SPI receiver / register-bank model.
`timescale 1ns/1ps
module tb_spi_controller;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   spi_controller_if bus_a();
   spi_controller_if bus_b();

   spi_controller #(.CLK_DIV(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
   spi_controller #(.CLK_DIV(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));

   int vec  = 0;
   int errs = 0;

   // ---------------- receiver / peripheral model ----------------
   logic sclk_w[2], copi_w[2], ncs_w[2], done_w[2], err_w[2], acc_w[2];
   always_comb begin
      sclk_w[0] = bus_a.SCLK;  copi_w[0] = bus_a.COPI;  ncs_w[0] = bus_a.nCS;
      done_w[0] = bus_a.done;  err_w[0]  = bus_a.err;
      acc_w[0]  = bus_a.req_valid && bus_a.req_ready;
      sclk_w[1] = bus_b.SCLK;  copi_w[1] = bus_b.COPI;  ncs_w[1] = bus_b.nCS;
      done_w[1] = bus_b.done;  err_w[1]  = bus_b.err;
      acc_w[1]  = bus_b.req_valid && bus_b.req_ready;
   end

   int cyc = 0;
   int low_run[2], last_low[2], high_run[2], last_high[2], rises[2], frames[2];
   int done_cnt[2], err_cnt[2], acc_cnt[2], acc_cyc[2], prev_acc_cyc[2], done_cyc[2];
   int viol[2], ncs_falls[2];
   logic [15:0] sh[2], last_frame[2];
   logic [7:0]  regs[2][5];
   logic sclk_p[2], copi_p[2], ncs_p[2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         low_run[i] = 0; last_low[i] = 0; high_run[i] = 0; last_high[i] = 0; rises[i] = 0;
         frames[i] = 0; done_cnt[i] = 0; err_cnt[i] = 0; acc_cnt[i] = 0; acc_cyc[i] = 0;
         prev_acc_cyc[i] = 0; done_cyc[i] = 0; viol[i] = 0; ncs_falls[i] = 0;
         sh[i] = '0; last_frame[i] = '0; sclk_p[i] = 1'b0; copi_p[i] = 1'b0; ncs_p[i] = 1'b1;
         for (int r = 0; r < 5; r++) regs[i][r] = 8'h00;
      end
   end

   always @(posedge clk) begin
      cyc++;
      for (int i = 0; i < 2; i++) begin
         if (acc_w[i] === 1'b1 && rst_n === 1'b1) begin
            acc_cnt[i]++; prev_acc_cyc[i] = acc_cyc[i]; acc_cyc[i] = cyc;
         end
         if (done_w[i] === 1'b1) begin done_cnt[i]++; done_cyc[i] = cyc; end
         if (err_w[i] === 1'b1) err_cnt[i]++;
         if (sclk_w[i] === 1'b1 && ncs_w[i] === 1'b1) viol[i]++;
         if (sclk_w[i] === 1'b1 && sclk_p[i] === 1'b1 && copi_w[i] !== copi_p[i]) viol[i]++;
         if (ncs_w[i] === 1'b0) begin
            if (ncs_p[i] === 1'b1) begin ncs_falls[i]++; last_high[i] = high_run[i]; end
            low_run[i]++;
            if (sclk_w[i] === 1'b1 && sclk_p[i] === 1'b0) begin
               sh[i] = {sh[i][14:0], copi_w[i]}; rises[i]++;
            end
         end else begin
            if (ncs_p[i] === 1'b0) begin
               last_low[i] = low_run[i];
               if (rises[i] == 16) begin
                  last_frame[i] = sh[i]; frames[i]++;
                  if (sh[i][15] && sh[i][14:8] < 7'd5) regs[i][sh[i][14:8]] = sh[i][7:0];
               end
               high_run[i] = 0;
            end
            high_run[i]++; low_run[i] = 0; rises[i] = 0;
         end
         sclk_p[i] = sclk_w[i]; copi_p[i] = copi_w[i]; ncs_p[i] = ncs_w[i];
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic send_a(input logic [6:0] a, input logic [7:0] d);
      int n = 0;
      @(negedge clk);
      while (bus_a.req_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
      if (bus_a.req_ready !== 1'b1) begin
         errs++; $display("FAIL send_timeout: req_ready=%b, required 1", bus_a.req_ready);
      end
      bus_a.req_addr = a; bus_a.req_data = d; bus_a.req_valid = 1'b1;
      @(negedge clk);
      bus_a.req_valid = 1'b0;
   endtask

   task automatic wait_done(input int i, input int target);
      int n = 0;
      while (done_cnt[i] < target && n < 1000) begin @(negedge clk); n++; end
      if (done_cnt[i] < target) begin
         errs++; $display("FAIL done_timeout[%0d]: done count %0d, required %0d", i, done_cnt[i], target);
      end
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst_n = 1'b0;
      bus_a.req_valid = 1'b0; bus_a.req_addr = '0; bus_a.req_data = '0;
      bus_b.req_valid = 1'b0; bus_b.req_addr = '0; bus_b.req_data = '0;
      repeat (3) @(negedge clk);
      vec++; if (bus_a.nCS !== 1'b1) begin errs++; $display("FAIL reset_ncs: got %b want 1", bus_a.nCS); end
      vec++; if (bus_a.SCLK !== 1'b0) begin errs++; $display("FAIL reset_sclk: got %b want 0", bus_a.SCLK); end
      vec++; if (bus_a.COPI !== 1'b0) begin errs++; $display("FAIL reset_copi: got %b want 0", bus_a.COPI); end
      vec++; if (bus_a.req_ready !== 1'b1) begin errs++; $display("FAIL reset_ready: got %b want 1", bus_a.req_ready); end
      vec++; if (bus_a.busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b want 0", bus_a.busy); end
      vec++; if (bus_a.done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b want 0", bus_a.done); end
      vec++; if (bus_a.err !== 1'b0) begin errs++; $display("FAIL reset_err: got %b want 0", bus_a.err); end
      vec++; if (bus_b.nCS !== 1'b1) begin errs++; $display("FAIL reset_ncs_b: got %b want 1", bus_b.nCS); end
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_single_write();
      int d0 = done_cnt[0];
      send_a(7'h00, 8'hA5);
      // first negedge after the accept edge: frame started, MSB (write flag) on COPI
      vec++; if (bus_a.nCS !== 1'b0) begin errs++; $display("FAIL single_ncs_fall: got %b want 0", bus_a.nCS); end
      vec++; if (bus_a.busy !== 1'b1) begin errs++; $display("FAIL single_busy: got %b want 1", bus_a.busy); end
      vec++; if (bus_a.req_ready !== 1'b0) begin errs++; $display("FAIL single_ready_low: got %b want 0", bus_a.req_ready); end
      vec++; if (bus_a.COPI !== 1'b1) begin errs++; $display("FAIL single_copi_msb: got %b want 1", bus_a.COPI); end
      wait_done(0, d0 + 1);
      repeat (10) @(negedge clk);
      vec++; if (last_frame[0] !== 16'h80A5) begin errs++; $display("FAIL single_frame: got %h want 80a5", last_frame[0]); end
      vec++; if (last_low[0] != 132) begin errs++; $display("FAIL single_ncs_low: got %0d want 132", last_low[0]); end
      vec++; if (done_cnt[0] - d0 != 1) begin errs++; $display("FAIL single_done_count: got %0d want 1", done_cnt[0] - d0); end
      // done visible after accept edge + 132, seen by the monitor one edge later
      vec++; if (done_cyc[0] - acc_cyc[0] != 133) begin errs++; $display("FAIL single_done_time: got %0d want 133", done_cyc[0] - acc_cyc[0]); end
      vec++; if (regs[0][0] !== 8'hA5) begin errs++; $display("FAIL single_reg0: got %h want a5", regs[0][0]); end
      vec++; if (bus_a.req_ready !== 1'b1) begin errs++; $display("FAIL single_ready_back: got %b want 1", bus_a.req_ready); end
      vec++; if (viol[0] != 0) begin errs++; $display("FAIL single_sclk_rules: got %0d want 0", viol[0]); end
   endtask

   task automatic test_back_to_back();
      int a0 = acc_cnt[0];
      int d0 = done_cnt[0];
      int n  = 0;
      @(negedge clk);
      bus_a.req_addr = 7'h04; bus_a.req_data = 8'h80; bus_a.req_valid = 1'b1;
      while (acc_cnt[0] < a0 + 1 && n < 300) begin @(negedge clk); n++; end
      bus_a.req_addr = 7'h01; bus_a.req_data = 8'h3C;
      n = 0;
      while (acc_cnt[0] < a0 + 2 && n < 300) begin @(negedge clk); n++; end
      bus_a.req_valid = 1'b0;
      vec++; if (acc_cnt[0] - a0 != 2) begin errs++; $display("FAIL b2b_accepts: got %0d want 2", acc_cnt[0] - a0); end
      wait_done(0, d0 + 2);
      repeat (10) @(negedge clk);
      vec++; if (acc_cyc[0] - prev_acc_cyc[0] != 136) begin errs++; $display("FAIL b2b_spacing: got %0d want 136", acc_cyc[0] - prev_acc_cyc[0]); end
      vec++; if (last_high[0] != 4) begin errs++; $display("FAIL b2b_ncs_gap: got %0d want 4", last_high[0]); end
      vec++; if (regs[0][4] !== 8'h80) begin errs++; $display("FAIL b2b_pwm_duty: got %h want 80", regs[0][4]); end
      vec++; if (regs[0][1] !== 8'h3C) begin errs++; $display("FAIL b2b_reg1: got %h want 3c", regs[0][1]); end
      vec++; if (last_frame[0] !== 16'h813C) begin errs++; $display("FAIL b2b_frame: got %h want 813c", last_frame[0]); end
   endtask

   task automatic test_input_stability();
      int d0 = done_cnt[0];
      int f0 = frames[0];
      int a0 = acc_cnt[0];
      send_a(7'h03, 8'h69);
      repeat (40) @(negedge clk);
      bus_a.req_data = 8'hFF; bus_a.req_valid = 1'b1;
      repeat (5) @(negedge clk);
      bus_a.req_valid = 1'b0;
      repeat (3) @(negedge clk);
      bus_a.req_addr = 7'h02; bus_a.req_valid = 1'b1;
      repeat (3) @(negedge clk);
      bus_a.req_valid = 1'b0;
      wait_done(0, d0 + 1);
      repeat (150) @(negedge clk);
      vec++; if (last_frame[0] !== 16'h8369) begin errs++; $display("FAIL stable_frame: got %h want 8369", last_frame[0]); end
      vec++; if (regs[0][3] !== 8'h69) begin errs++; $display("FAIL stable_reg3: got %h want 69", regs[0][3]); end
      vec++; if (frames[0] - f0 != 1) begin errs++; $display("FAIL stable_frames: got %0d want 1", frames[0] - f0); end
      vec++; if (acc_cnt[0] - a0 != 1) begin errs++; $display("FAIL stable_accepts: got %0d want 1", acc_cnt[0] - a0); end
   endtask

   task automatic test_reset_mid_frame();
      int d0 = done_cnt[0];
      int f0 = frames[0];
      int n  = 0;
      send_a(7'h02, 8'h77);
      while (rises[0] < 8 && n < 300) begin @(negedge clk); n++; end
      vec++; if (rises[0] != 8) begin errs++; $display("FAIL midrst_rises: got %0d want 8", rises[0]); end
      rst_n = 1'b0;
      @(negedge clk);
      vec++; if (bus_a.nCS !== 1'b1) begin errs++; $display("FAIL midrst_ncs: got %b want 1", bus_a.nCS); end
      vec++; if (bus_a.SCLK !== 1'b0) begin errs++; $display("FAIL midrst_sclk: got %b want 0", bus_a.SCLK); end
      vec++; if (bus_a.COPI !== 1'b0) begin errs++; $display("FAIL midrst_copi: got %b want 0", bus_a.COPI); end
      vec++; if (bus_a.req_ready !== 1'b1) begin errs++; $display("FAIL midrst_ready: got %b want 1", bus_a.req_ready); end
      vec++; if (bus_a.busy !== 1'b0) begin errs++; $display("FAIL midrst_busy: got %b want 0", bus_a.busy); end
      rst_n = 1'b1;
      repeat (200) @(negedge clk);
      vec++; if (done_cnt[0] != d0) begin errs++; $display("FAIL midrst_done: got %0d want %0d", done_cnt[0], d0); end
      vec++; if (frames[0] != f0) begin errs++; $display("FAIL midrst_frames: got %0d want %0d", frames[0], f0); end
      vec++; if (regs[0][2] !== 8'h00) begin errs++; $display("FAIL midrst_reg2: got %h want 00", regs[0][2]); end
   endtask

   task automatic test_addr_check();
      int d0 = done_cnt[0];
      int e0 = err_cnt[0];
      int c0 = ncs_falls[0];
      send_a(7'h05, 8'h11);
`ifdef SPI_CTRL_ADDR_CHECK_EN
      vec++; if (bus_a.err !== 1'b1) begin errs++; $display("FAIL addr_err_pulse: got %b want 1", bus_a.err); end
      vec++; if (bus_a.req_ready !== 1'b1) begin errs++; $display("FAIL addr_ready: got %b want 1", bus_a.req_ready); end
      vec++; if (bus_a.nCS !== 1'b1) begin errs++; $display("FAIL addr_ncs: got %b want 1", bus_a.nCS); end
      repeat (20) @(negedge clk);
      vec++; if (err_cnt[0] - e0 != 1) begin errs++; $display("FAIL addr_err_count: got %0d want 1", err_cnt[0] - e0); end
      vec++; if (ncs_falls[0] != c0) begin errs++; $display("FAIL addr_no_bus: got %0d want %0d", ncs_falls[0], c0); end
      vec++; if (done_cnt[0] != d0) begin errs++; $display("FAIL addr_no_done: got %0d want %0d", done_cnt[0], d0); end
`else
      vec++; if (bus_a.err !== 1'b0) begin errs++; $display("FAIL addr_err_tied: got %b want 0", bus_a.err); end
      wait_done(0, d0 + 1);
      repeat (10) @(negedge clk);
      vec++; if (last_frame[0] !== 16'h8511) begin errs++; $display("FAIL addr_frame: got %h want 8511", last_frame[0]); end
      vec++; if (done_cnt[0] - d0 != 1) begin errs++; $display("FAIL addr_done: got %0d want 1", done_cnt[0] - d0); end
      vec++; if (err_cnt[0] != e0) begin errs++; $display("FAIL addr_err_count: got %0d want %0d", err_cnt[0], e0); end
      vec++; if (ncs_falls[0] - c0 != 1) begin errs++; $display("FAIL addr_one_frame: got %0d want 1", ncs_falls[0] - c0); end
`endif
   endtask

   task automatic test_clkdiv2();
      int d0 = done_cnt[1];
      @(negedge clk);
      bus_b.req_addr = 7'h02; bus_b.req_data = 8'h5A; bus_b.req_valid = 1'b1;
      @(negedge clk);
      bus_b.req_valid = 1'b0;
      wait_done(1, d0 + 1);
      repeat (5) @(negedge clk);
      vec++; if (last_low[1] != 66) begin errs++; $display("FAIL div2_ncs_low: got %0d want 66", last_low[1]); end
      vec++; if (last_frame[1] !== 16'h825A) begin errs++; $display("FAIL div2_frame: got %h want 825a", last_frame[1]); end
      vec++; if (regs[1][2] !== 8'h5A) begin errs++; $display("FAIL div2_reg2: got %h want 5a", regs[1][2]); end
      vec++; if (done_cyc[1] - acc_cyc[1] != 67) begin errs++; $display("FAIL div2_done_time: got %0d want 67", done_cyc[1] - acc_cyc[1]); end
      vec++; if (viol[1] != 0) begin errs++; $display("FAIL div2_sclk_rules: got %0d want 0", viol[1]); end
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_back_to_back();
      test_input_stability();
      test_reset_mid_frame();
      test_addr_check();
      test_clkdiv2();
      $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
      $finish;
   end
endmodule
